// File: rtl/ether_pkg.sv
// Shared Ethernet constants and TX state encoding for the debug packet path.
// Used by the debug TX block and its CRC helper; meant to be reused by the RX FCS checker.
package ether_pkg;

  localparam logic [7:0]  ETH_PREAMBLE     = 8'h55;
  localparam logic [7:0]  ETH_SFD          = 8'hD5;
  localparam int unsigned ETH_PREAMBLE_LEN = 7;
  localparam int unsigned ETH_MIN_PAYLOAD  = 60;
  localparam int unsigned ETH_FCS_LEN      = 4;

  localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StData,
    StFcs,
    StIfg
  } tx_state_e;

  // FCS is the inverted running CRC, transmitted least-significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc;
    return fcs[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ether_debug_packet_tx_if.sv
// Host and GMII TX signal bundle for ether_debug_packet_tx.
//  master: host side (drives buffer writes, length, start; observes status and GMII TX)
//  slave : the transmitter itself
//  wr_en/wr_addr/wr_data  buffer write port
//  length                 payload byte count, sampled on start
//  start/busy/done        transmit request and status
//  phy_tx_en/er/txd       GMII transmit outputs
interface ether_debug_packet_tx_if #(
  parameter int unsigned ADDR_W = 11
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] length;
  logic              start;
  logic              busy;
  logic              done;
  logic              phy_tx_en;
  logic              phy_tx_er;
  logic [7:0]        phy_txd;

  modport master (
    output wr_en, wr_addr, wr_data, length, start,
    input  busy, done, phy_tx_en, phy_tx_er, phy_txd
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, length, start,
    output busy, done, phy_tx_en, phy_tx_er, phy_txd
  );

endinterface

// File: rtl/ether_crc32_d8.sv
// Combinational byte-wide Ethernet CRC-32 update (reflected polynomial, data LSB first).
//  crc_in   running CRC before this byte
//  data     byte being added to the CRC
//  crc_out  running CRC after this byte
module ether_crc32_d8
  import ether_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/ether_debug_packet_tx.sv
// Debug frame transmitter. The host fills a byte buffer while idle, then pulses start; the
// block sends one GMII frame (preamble, SFD, payload with optional zero pad, CRC-32 FCS) and
// holds busy through the inter-frame gap.
//  clk_125  125 MHz clock for all logic and GMII TX
//  rst      asynchronous active-high reset
//  bus      slave side of ether_debug_packet_tx_if (buffer writes, length/start, status,
//           GMII phy_tx_en/phy_tx_er/phy_txd)
module ether_debug_packet_tx
  import ether_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter bit          PAD_EN     = 1'b1,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic                   clk_125,
  input  logic                   rst,
  ether_debug_packet_tx_if.slave bus
);

  localparam logic [ADDR_W-1:0] MinLen  = ADDR_W'(ETH_MIN_PAYLOAD);
  localparam logic [ADDR_W-1:0] PreLast = ADDR_W'(ETH_PREAMBLE_LEN - 1);
  localparam logic [ADDR_W-1:0] FcsLast = ADDR_W'(ETH_FCS_LEN - 1);
  localparam logic [ADDR_W-1:0] IfgLast = ADDR_W'(IFG_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] frame_len_q, frame_len_d;
  logic [31:0]       crc_q, crc_d, crc_next;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        txd_q, txd_d;

  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        rd_data_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] byte_idx;
  logic [7:0]        pay_byte;
  logic [ADDR_W-1:0] start_frame_len;

  // Buffer RAM: writes are frozen while a frame is in flight so its content stays stable.
  always_ff @(posedge clk_125) begin
    if (bus.wr_en && !busy_q) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  // Outputs are registered from next-state, so rd_data_q must already hold the byte that goes
  // on the wire one cycle later: the read runs two bytes ahead of the byte currently shown.
  // Address 0 is held through the preamble so byte 0 is ready during SFD.
  always_comb begin
    unique case (state_q)
      StSfd:   rd_addr = ADDR_W'(1);
      StData:  rd_addr = cnt_q + ADDR_W'(2);
      default: rd_addr = '0;
    endcase
  end

  // Index of the payload byte that will be on the wire next cycle.
  assign byte_idx = (state_q == StData) ? cnt_q + ADDR_W'(1) : '0;
  // Bytes past the host length are pad and always zero, whatever the buffer holds.
  assign pay_byte = (byte_idx < len_q) ? rd_data_q : 8'h00;

  assign start_frame_len = (PAD_EN && (bus.length < MinLen)) ? MinLen : bus.length;

  ether_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (pay_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    frame_len_d = frame_len_q;
    crc_d       = crc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_en_d     = 1'b0;
    txd_d       = 8'h00;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.start && !busy_q) begin
          state_d     = StPre;
          cnt_d       = '0;
          len_d       = bus.length;
          frame_len_d = start_frame_len;
          crc_d       = CRC32_INIT;
          busy_d      = 1'b1;
          tx_en_d     = 1'b1;
          txd_d       = ETH_PREAMBLE;
        end
      end

      StPre: begin
        tx_en_d = 1'b1;
        if (cnt_q == PreLast) begin
          state_d = StSfd;
          cnt_d   = '0;
          txd_d   = ETH_SFD;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
          txd_d = ETH_PREAMBLE;
        end
      end

      StSfd: begin
        tx_en_d = 1'b1;
        cnt_d   = '0;
        if (frame_len_q == '0) begin
          // Empty unpadded payload: CRC is still the init value, FCS follows SFD directly.
          state_d = StFcs;
          txd_d   = fcs_byte(crc_q, 2'd0);
        end else begin
          state_d = StData;
          txd_d   = pay_byte;
          crc_d   = crc_next;
        end
      end

      StData: begin
        tx_en_d = 1'b1;
        if (byte_idx == frame_len_q) begin
          // crc_q already covers the byte on the wire now, i.e. the last one.
          state_d = StFcs;
          cnt_d   = '0;
          txd_d   = fcs_byte(crc_q, 2'd0);
        end else begin
          cnt_d = byte_idx;
          txd_d = pay_byte;
          crc_d = crc_next;
        end
      end

      StFcs: begin
        if (cnt_q == FcsLast) begin
          state_d = StIfg;
          cnt_d   = '0;
          done_d  = (IfgLast == '0);
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          tx_en_d = 1'b1;
          txd_d   = fcs_byte(crc_q, cnt_q[1:0] + 2'd1);
        end
      end

      StIfg: begin
        if (cnt_q == IfgLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + ADDR_W'(1);
          done_d = (cnt_d == IfgLast);
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      frame_len_q <= '0;
      crc_q       <= CRC32_INIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      txd_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
      crc_q       <= crc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_en_q     <= tx_en_d;
      txd_q       <= txd_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.phy_tx_en = tx_en_q;
  assign bus.phy_tx_er = 1'b0;
  assign bus.phy_txd   = txd_q;

endmodule
